frequency_measurement_scheduler: RTL
====================================

Name: frequency_measurement_scheduler

Overview:
Sequences one measurement cycle for the pixel frequency analyzers: clear, measurement window, result readout, interrupt.
- Drives the analyzers' clear/enable in place of free-running external start/stop strobes.
- Reads each result word through a mux index and writes it into the AXI slave register file over the register_operation/register_number/register_write interface.
- Raises irq when the register file holds a complete, consistent result set.

Parameters:
NUM_RESULTS, 6, number of 32-bit result words read out per measurement (valid 1..7).
BASE_REGISTER, 0, register_number used for the first result word.
CLEAR_CYCLES, 4, cycles analyzer_clear is held high before the window opens (>=1).
REGISTER_WRITE_OPERATION, 2, value driven on register_operation during a write; idle value is 0.

Ports:
clock  in  1  single block clock (AXI clock domain)
reset  in  1  synchronous, active-high reset
cmd_start  in  1  single-cycle pulse, begins a measurement when idle
cmd_abort  in  1  level/pulse, returns to idle from any state
cfg_window_cycles  in  32  measurement window length in clock cycles
cfg_continuous  in  1  1 = restart automatically after irq_ack
analyzer_clear  out  1  clear to all frequency analyzers
analyzer_enable  out  1  enable to all frequency analyzers
result_index  out  3  selects the result word presented on result_data
result_data  in  32  selected analyzer result, combinational from result_index
register_operation  out  2  REGISTER_WRITE_OPERATION while writing, else 0
register_number  out  8  target register, BASE_REGISTER + k
register_write  out  32  data for the register write
register_ready  in  1  register file accepted the current write
irq  out  1  results valid, level until irq_ack
irq_ack  in  1  single-cycle acknowledge
busy  out  1  high in every state except IDLE

Behaviour:
Reset (sync, active-high, overrides all inputs):
- State = IDLE.
- analyzer_clear=0, analyzer_enable=0, result_index=0, register_operation=0, register_number=0, register_write=0, irq=0, busy=0.

States and transitions:
- IDLE: all outputs at reset values.
  - cmd_start=1 -> CLEAR.
  - cmd_start while not IDLE is ignored.
- CLEAR: analyzer_clear=1 for exactly CLEAR_CYCLES cycles, then -> MEASURE.
  - Window counter loads cfg_window_cycles on the last CLEAR cycle; a value of 0 is loaded as 1.
- MEASURE: analyzer_enable=1 for exactly W cycles (W = loaded value), decrementing counter.
  - Counter reaching 1 -> SETTLE next cycle.
  - cfg_window_cycles changes during MEASURE have no effect.
- SETTLE: one cycle, enable=0 and clear=0; analyzer outputs stabilise. k=0. -> SELECT.
- SELECT: result_index=k for one cycle. -> WRITE, latching register_write<=result_data and register_number<=BASE_REGISTER+k.
- WRITE: register_operation=REGISTER_WRITE_OPERATION.
  - register_number and register_write are held stable until register_ready=1 (a ready in the first WRITE cycle counts).
  - On accept: register_operation=0 next cycle. If k==NUM_RESULTS-1 -> IRQ, else k<=k+1 -> SELECT.
  - Each word takes at least 2 cycles; there is no timeout.
- IRQ: irq=1.
  - irq_ack=1 -> irq=0 next cycle; cfg_continuous is sampled in that cycle. 1 -> CLEAR, 0 -> IDLE.
  - cmd_start in IRQ is ignored.
- Abort: cmd_abort=1 in any non-IDLE state -> IDLE next cycle.
  - All outputs return to idle values and irq is dropped.
  - A write in progress is abandoned; the register file keeps whatever words were already accepted.
  - Abort wins over simultaneous irq_ack, register_ready or window expiry.
  - cmd_abort in IDLE has no effect; cmd_start and cmd_abort together in IDLE -> stay IDLE.

General rules:
- Outputs are registered except busy, which is decoded from state.
- register_operation is never nonzero outside WRITE.
- analyzer_clear and analyzer_enable are never high together.

Test Plan:
- Reset, then cmd_start with window=10, NUM_RESULTS=6, register_ready tied 1 -> clear high for 4 cycles, enable high for exactly 10 cycles, six writes to registers 0..5 carrying result_data for indices 0..5, then irq=1. Total from cmd_start to irq = 4+10+1+12 = 27 cycles.
- register_ready withheld 3 cycles on word 2 -> register_operation=2, register_number=2 and register_write are held constant for those cycles; no other word is skipped or duplicated.
- cfg_window_cycles=0 -> enable high for exactly 1 cycle; cfg_window_cycles changed from 10 to 3 mid-MEASURE -> window stays 10.
- cmd_abort during MEASURE and again during word 3 WRITE -> IDLE next cycle, enable=0, register_operation=0, irq never asserted; a later cmd_start runs normally.
- cfg_continuous=1, irq_ack -> irq low next cycle and clear reasserts immediately; cfg_continuous=0 at ack -> IDLE, busy=0.
- cmd_start during MEASURE and during IRQ -> ignored, sequence timing unchanged; reset asserted mid-READOUT together with register_ready -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/frequency_measurement_scheduler_if.sv
// Register-file write port between the measurement scheduler and the AXI slave register block.
interface frequency_measurement_scheduler_if;
    logic [1:0]  register_operation;
    logic [7:0]  register_number;
    logic [31:0] register_write;
    logic        register_ready;

    modport master (
        output register_operation,
        output register_number,
        output register_write,
        input  register_ready
    );

    modport slave (
        input  register_operation,
        input  register_number,
        input  register_write,
        output register_ready
    );
endinterface

// File: rtl/frequency_measurement_scheduler.sv
// Sequences one analyzer measurement: clear, timed enable window, result readout into the
// register file, then a level interrupt until acknowledged.
module frequency_measurement_scheduler #(
    parameter int NUM_RESULTS              = 6,
    parameter int BASE_REGISTER            = 0,
    parameter int CLEAR_CYCLES             = 4,
    parameter int REGISTER_WRITE_OPERATION = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                cmd_start,
    input  logic                                cmd_abort,
    input  logic [31:0]                         cfg_window_cycles,
    input  logic                                cfg_continuous,
    output logic                                analyzer_clear,
    output logic                                analyzer_enable,
    output logic [2:0]                          result_index,
    input  logic [31:0]                         result_data,
    frequency_measurement_scheduler_if.master   reg_if,
    output logic                                irq,
    input  logic                                irq_ack,
    output logic                                busy
);

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [2:0] LAST_K = 3'(NUM_RESULTS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        SETTLE,
        SELECT,
        WRITE,
        IRQ
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] clr_cnt;
    logic [31:0]   win_cnt;
    logic [2:0]    k;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_start && !cmd_abort) state_next = CLEAR;
            CLEAR:   if (clr_cnt == '0) state_next = MEASURE;
            MEASURE: if (win_cnt == 32'd1) state_next = SETTLE;
            SETTLE:  state_next = SELECT;
            SELECT:  state_next = WRITE;
            WRITE:   if (reg_if.register_ready) state_next = (k == LAST_K) ? IRQ : SELECT;
            IRQ:     if (irq_ack) state_next = cfg_continuous ? CLEAR : IDLE;
            default: state_next = IDLE;
        endcase
        // Abort dominates every other event once a sequence is running.
        if (cmd_abort && state != IDLE) state_next = IDLE;
    end

    // Sequencing counters: clear length, window length, result word index.
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_cnt <= '0;
            win_cnt <= '0;
            k       <= '0;
        end else begin
            if (state != CLEAR) clr_cnt <= CW'(CLEAR_CYCLES - 1);
            else                clr_cnt <= clr_cnt - 1'b1;

            if (state == CLEAR && clr_cnt == '0)
                win_cnt <= (cfg_window_cycles == 32'd0) ? 32'd1 : cfg_window_cycles;
            else if (state == MEASURE)
                win_cnt <= win_cnt - 32'd1;

            if (state == SETTLE)
                k <= '0;
            else if (state == WRITE && state_next == SELECT)
                k <= k + 3'd1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            analyzer_clear            <= 1'b0;
            analyzer_enable           <= 1'b0;
            irq                       <= 1'b0;
            result_index              <= '0;
            reg_if.register_operation <= '0;
            reg_if.register_number    <= '0;
            reg_if.register_write     <= '0;
        end else begin
            analyzer_clear            <= (state_next == CLEAR);
            analyzer_enable           <= (state_next == MEASURE);
            irq                       <= (state_next == IRQ);
            reg_if.register_operation <= (state_next == WRITE) ? 2'(REGISTER_WRITE_OPERATION) : 2'd0;
            if (state_next == IDLE) begin
                result_index           <= '0;
                reg_if.register_number <= '0;
                reg_if.register_write  <= '0;
            end else begin
                if (state_next == SELECT)
                    result_index <= (state == WRITE) ? (k + 3'd1) : 3'd0;
                if (state == SELECT) begin
                    reg_if.register_number <= 8'(BASE_REGISTER) + {5'd0, k};
                    reg_if.register_write  <= result_data;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
